// File: rtl/ram_mux_pkg.sv
// Shared types and helpers for the N-port RAM multiplexer.
package ram_mux_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  localparam int MAX_PORTS = 8;

  // Index of the first set bit at or after start, wrapping at n; -1 when vec has no bit set.
  function automatic int first_set_from(input logic [MAX_PORTS-1:0] vec, input int n, input int start);
    int j;
    first_set_from = -1;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (i < n) begin
        j = start + i;
        if (j >= n) j = j - n;
        if (vec[j]) first_set_from = j;
      end
    end
  endfunction

endpackage

// File: rtl/ram_mux_nport_if.sv
// Master-side request/grant/response bus shared by all ports of the RAM multiplexer.
interface ram_mux_nport_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IN_WIDTH   = 32
);
  logic [NUM_PORTS-1:0]                 port_req;
  logic [NUM_PORTS-1:0]                 port_gnt;
  logic [NUM_PORTS-1:0]                 port_rvalid;
  logic [NUM_PORTS-1:0]                 port_we;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS-1:0][IN_WIDTH/8-1:0] port_be;
  logic [NUM_PORTS-1:0][IN_WIDTH-1:0]   port_wdata;
  logic [NUM_PORTS-1:0][IN_WIDTH-1:0]   port_rdata;

  modport master (
    output port_req, port_addr, port_we, port_be, port_wdata,
    input  port_gnt, port_rvalid, port_rdata
  );

  modport slave (
    input  port_req, port_addr, port_we, port_be, port_wdata,
    output port_gnt, port_rvalid, port_rdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational arbiter with a rotating start pointer; fixed mode always starts the search at 0.
module rr_arbiter import ram_mux_pkg::*; #(
  parameter int        NUM_PORTS = 4,
  parameter arb_mode_e ARB_MODE  = ARB_FIXED,
  localparam int       IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_any_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  int               win;

  always_comb begin
    win       = first_set_from(MAX_PORTS'(req_i), NUM_PORTS,
                               (ARB_MODE == ARB_RR) ? int'(rr_ptr_q) : 0);
    gnt_any_o = (win >= 0);
    gnt_idx_o = gnt_any_o ? IDX_W'(win) : '0;
    gnt_o     = '0;
    if (gnt_any_o) gnt_o[gnt_idx_o] = 1'b1;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_any_o) begin
      rr_ptr_d = (int'(gnt_idx_o) == NUM_PORTS - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/ram_mux_nport.sv
// N-port arbiter in front of one single-ported SRAM, with sub-word adaptation and a
// latency-matched response pipeline that routes read data back to the granted port.
module ram_mux_nport import ram_mux_pkg::*; #(
  parameter int        NUM_PORTS   = 4,
  parameter int        ADDR_WIDTH  = 32,
  parameter int        OUT_WIDTH   = 32,
  parameter int        IN_WIDTH    = 32,
  parameter int        RAM_LATENCY = 1,
  parameter arb_mode_e ARB_MODE    = ARB_FIXED
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram_mux_nport_if.slave         port_if,
  output logic                   ram_en_o,
  output logic [ADDR_WIDTH-1:0]  ram_addr_o,
  output logic                   ram_we_o,
  output logic [OUT_WIDTH/8-1:0] ram_be_o,
  output logic [OUT_WIDTH-1:0]   ram_wdata_o,
  input  logic [OUT_WIDTH-1:0]   ram_rdata_i
);

  localparam int RATIO     = OUT_WIDTH / IN_WIDTH;
  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int IDX_W     = $clog2(NUM_PORTS);
  localparam int OFF_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OFF_LSB   = $clog2(IN_BYTES);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } resp_stage_t;

  logic                  gnt_any;
  logic [IDX_W-1:0]      gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [IN_BYTES-1:0]   sel_be;
  logic [IN_WIDTH-1:0]   sel_wdata;
  logic [OFF_W-1:0]      sel_off;
  resp_stage_t           stage_d;
  resp_stage_t           stage_q [RAM_LATENCY];
  resp_stage_t           resp_out;
  logic [IN_WIDTH-1:0]   rdata_sel;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (port_if.port_req),
    .gnt_o     (port_if.port_gnt),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  assign sel_addr  = port_if.port_addr[gnt_idx];
  assign sel_we    = port_if.port_we[gnt_idx];
  assign sel_be    = port_if.port_be[gnt_idx];
  assign sel_wdata = port_if.port_wdata[gnt_idx];

  // Sub-word lane within the RAM word; a full-width master always sits in lane 0.
  if (RATIO > 1) begin : g_off
    assign sel_off = sel_addr[OFF_LSB +: OFF_W];
  end else begin : g_no_off
    assign sel_off = '0;
  end

  assign ram_en_o    = |port_if.port_req;
  assign ram_addr_o  = sel_addr;
  assign ram_we_o    = sel_we;
  assign ram_be_o    = OUT_BYTES'(sel_be) << (sel_off * IN_BYTES);
  assign ram_wdata_o = {RATIO{sel_wdata}};

  assign stage_d = '{valid: gnt_any, idx: gnt_idx, off: sel_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < RAM_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign resp_out  = stage_q[RAM_LATENCY-1];
  assign rdata_sel = IN_WIDTH'(ram_rdata_i >> (resp_out.off * IN_WIDTH));

  always_comb begin
    port_if.port_rvalid = '0;
    if (resp_out.valid) port_if.port_rvalid[resp_out.idx] = 1'b1;
    for (int k = 0; k < NUM_PORTS; k++) port_if.port_rdata[k] = rdata_sel;
  end

endmodule

// File: tb/tb_ram_mux_nport.sv
// Scoreboard bench: a round-robin byte-wide instance and a fixed-priority full-width instance.
module tb_ram_mux_nport;
  import ram_mux_pkg::*;

  localparam int NP    = 4;
  localparam int LAT_R = 3;
  localparam int LAT_F = 1;

  typedef struct {
    int          port;
    int          due;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ptrR = 0;
  exp_t qR[$];
  exp_t qF[$];
  logic [7:0] refMem [64];

  logic        rEn, rWe, fEn, fWe;
  logic [31:0] rAddr, rWdata, rRdata, fAddr, fWdata, fRdata;
  logic [3:0]  rBe, fBe;
  logic [31:0] mem [16];
  logic [31:0] rdPipe [LAT_R];
  logic        memReady = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_mux_nport_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .IN_WIDTH(8))  ifR ();
  ram_mux_nport_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .IN_WIDTH(32)) ifF ();

  ram_mux_nport #(
    .NUM_PORTS(NP), .ADDR_WIDTH(32), .OUT_WIDTH(32), .IN_WIDTH(8),
    .RAM_LATENCY(LAT_R), .ARB_MODE(ARB_RR)
  ) dutR (
    .clk(clk), .rst_n(rst_n), .port_if(ifR),
    .ram_en_o(rEn), .ram_addr_o(rAddr), .ram_we_o(rWe), .ram_be_o(rBe),
    .ram_wdata_o(rWdata), .ram_rdata_i(rRdata)
  );

  ram_mux_nport #(
    .NUM_PORTS(NP), .ADDR_WIDTH(32), .OUT_WIDTH(32), .IN_WIDTH(32),
    .RAM_LATENCY(LAT_F), .ARB_MODE(ARB_FIXED)
  ) dutF (
    .clk(clk), .rst_n(rst_n), .port_if(ifF),
    .ram_en_o(fEn), .ram_addr_o(fAddr), .ram_we_o(fWe), .ram_be_o(fBe),
    .ram_wdata_o(fWdata), .ram_rdata_i(fRdata)
  );

  function automatic logic [7:0] byteInit(int b);
    case (b)
      0: return 8'h44;
      1: return 8'h33;
      2: return 8'h22;
      3: return 8'h11;
      default: return 8'(b * 37 + 5);
    endcase
  endfunction

  // Word-wide SRAM behind the round-robin instance, read data delayed by LAT_R cycles.
  always @(posedge clk) begin
    logic [31:0] t;
    if (!memReady) begin
      for (int w = 0; w < 16; w++)
        mem[w] <= {byteInit(4*w+3), byteInit(4*w+2), byteInit(4*w+1), byteInit(4*w)};
      memReady <= 1'b1;
    end else begin
      for (int i = LAT_R - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
      rdPipe[0] <= mem[rAddr[5:2]];
      if (rEn && rWe) begin
        t = mem[rAddr[5:2]];
        for (int b = 0; b < 4; b++) if (rBe[b]) t[8*b +: 8] = rWdata[8*b +: 8];
        mem[rAddr[5:2]] <= t;
      end
    end
  end
  assign rRdata = rdPipe[LAT_R-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < NP; k++) begin
      ifR.port_req[k]   = 1'($urandom_range(0, 1));
      ifR.port_addr[k]  = 32'($urandom_range(0, 63));
      ifR.port_we[k]    = 1'($urandom_range(0, 1));
      ifR.port_be[k]    = 1'($urandom_range(0, 1));
      ifR.port_wdata[k] = 8'($urandom);
      ifF.port_req[k]   = 1'($urandom_range(0, 1));
      ifF.port_addr[k]  = $urandom;
      ifF.port_we[k]    = 1'($urandom_range(0, 1));
      ifF.port_be[k]    = 4'($urandom);
      ifF.port_wdata[k] = $urandom;
    end
    fRdata = $urandom;
  endtask

  task automatic setIdle();
    ifR.port_req = '0;
    ifF.port_req = '0;
  endtask

  // Reference arbitration and memory behaviour; pushes each grant's expected response.
  task automatic scoreCycle();
    int g;
    int j;
    logic [31:0] a;
    g = -1;
    for (int i = 0; i < NP; i++) begin
      j = (ptrR + i) % NP;
      if (g < 0 && ifR.port_req[j]) g = j;
    end
    checkOutput("rGnt", 32'(ifR.port_gnt), (g < 0) ? 32'd0 : (32'd1 << g));
    checkOutput("rEn", 32'(rEn), 32'(g >= 0));
    if (g >= 0) begin
      a = ifR.port_addr[g];
      checkOutput("rAddr", rAddr, a);
      checkOutput("rWe", 32'(rWe), 32'(ifR.port_we[g]));
      checkOutput("rBe", 32'(rBe), 32'(ifR.port_be[g]) << a[1:0]);
      checkOutput("rWdata", rWdata, {4{ifR.port_wdata[g]}});
      qR.push_back('{port: g, due: cyc + LAT_R, chk: !ifR.port_we[g], data: 32'(refMem[a[5:0]])});
      if (ifR.port_we[g] && ifR.port_be[g][0]) refMem[a[5:0]] = ifR.port_wdata[g];
      ptrR = (g + 1) % NP;
    end
    g = -1;
    for (int i = 0; i < NP; i++) if (g < 0 && ifF.port_req[i]) g = i;
    checkOutput("fGnt", 32'(ifF.port_gnt), (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      checkOutput("fAddr", fAddr, ifF.port_addr[g]);
      checkOutput("fBe", 32'(fBe), 32'(ifF.port_be[g]));
      checkOutput("fWdata", fWdata, ifF.port_wdata[g]);
      qF.push_back('{port: g, due: cyc + LAT_F, chk: 1'b1, data: 32'd0});
    end
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    scoreCycle();
  endtask

  // Response monitor: every rvalid must match the oldest outstanding grant and its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifR.port_rvalid != '0) begin
        if (qR.size() == 0) checkOutput("rUnexpectedRvalid", 32'(ifR.port_rvalid), 32'd0);
        else begin
          e = qR.pop_front();
          checkOutput("rRvalid", 32'(ifR.port_rvalid), 32'd1 << e.port);
          checkOutput("rDue", cyc, e.due);
          if (e.chk) checkOutput("rRdata", 32'(ifR.port_rdata[e.port]), e.data);
        end
      end
      while (qR.size() > 0 && qR[0].due < cyc) begin
        e = qR.pop_front();
        checkOutput("rMissingRvalid", 32'(cyc), 32'(e.due));
      end
      if (ifF.port_rvalid != '0) begin
        if (qF.size() == 0) checkOutput("fUnexpectedRvalid", 32'(ifF.port_rvalid), 32'd0);
        else begin
          e = qF.pop_front();
          checkOutput("fRvalid", 32'(ifF.port_rvalid), 32'd1 << e.port);
          checkOutput("fDue", cyc, e.due);
          checkOutput("fRdata", ifF.port_rdata[e.port], fRdata);
        end
      end
      while (qF.size() > 0 && qF[0].due < cyc) begin
        e = qF.pop_front();
        checkOutput("fMissingRvalid", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int b = 0; b < 64; b++) refMem[b] = byteInit(b);
    applyStimulus();
    setIdle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetRvalidR", 32'(ifR.port_rvalid), 32'd0);
    checkOutput("resetRvalidF", 32'(ifF.port_rvalid), 32'd0);
    nextEdge();
    rst_n = 1'b1;

    // Sub-word read, write, read-back on port 1 while the fixed instance sees 1010.
    for (int s = 0; s < 3; s++) begin
      nextEdge();
      applyStimulus();
      setIdle();
      ifR.port_req[1]   = 1'b1;
      ifR.port_addr[1]  = 32'h3;
      ifR.port_we[1]    = (s == 1);
      ifR.port_be[1]    = 1'b1;
      ifR.port_wdata[1] = 8'hA5;
      ifF.port_req      = 4'b1010;
      stepCycle();
      checkOutput("widthBe", 32'(rBe), 32'h8);
      checkOutput("fixedGnt1010", 32'(ifF.port_gnt), 32'h2);
      if (s == 1) checkOutput("widthWdata", rWdata, 32'hA5A5A5A5);
    end

    // Single-requester grants to 2, 0, 1 on consecutive cycles.
    for (int s = 0; s < 3; s++) begin
      nextEdge();
      applyStimulus();
      setIdle();
      ifR.port_req[(s == 0) ? 2 : (s == 1) ? 0 : 1] = 1'b1;
      stepCycle();
    end
    repeat (4) begin
      nextEdge();
      setIdle();
      stepCycle();
    end

    // Reset one cycle after a grant: the response is lost and the pointer restarts at 0.
    nextEdge();
    applyStimulus();
    setIdle();
    ifR.port_req[2] = 1'b1;
    stepCycle();
    nextEdge();
    rst_n = 1'b0;
    setIdle();
    qR.delete();
    qF.delete();
    ptrR = 0;
    stepCycle();
    checkOutput("midResetRvalid", 32'(ifR.port_rvalid), 32'd0);
    nextEdge();
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      applyStimulus();
      ifR.port_req = '1;
      ifF.port_req = '0;
      stepCycle();
      checkOutput("rrAllReq", 32'(ifR.port_gnt), 32'd1 << (s % NP));
      nextEdge();
    end

    for (int s = 0; s < 300; s++) begin
      applyStimulus();
      stepCycle();
      nextEdge();
    end

    repeat (6) begin
      setIdle();
      stepCycle();
      nextEdge();
    end
    checkOutput("drainR", 32'(qR.size()), 32'd0);
    checkOutput("drainF", 32'(qF.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
